// File: rtl/midi_pkg.sv
// midi_pkg: MIDI constants shared by the encoder and the parser.
// Holds the status opcodes, the evt_type encoding, the encoder FSM state
// encoding, and a helper that builds a status byte from an event.
package midi_pkg;

   // Status-byte high nibbles (bit 7 already set)
   localparam logic [3:0] MIDI_NOTE_OFF   = 4'h8;
   localparam logic [3:0] MIDI_NOTE_ON    = 4'h9;
   localparam logic [3:0] MIDI_POLY_AT    = 4'hA;
   localparam logic [3:0] MIDI_PITCH_BEND = 4'hE;

   typedef enum logic [1:0] {
      EVT_NOTE_OFF   = 2'd0,
      EVT_NOTE_ON    = 2'd1,
      EVT_POLY_AT    = 2'd2,
      EVT_PITCH_BEND = 2'd3
   } evt_type_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STATUS = 2'd1,
      ST_DATA1  = 2'd2,
      ST_DATA2  = 2'd3
   } state_e;

   // Status byte = opcode nibble followed by the channel nibble
   function automatic logic [7:0] midi_status(input logic [1:0] evt_type,
                                              input logic [3:0] channel);
      logic [3:0] op;
      case (evt_type)
         EVT_NOTE_OFF:   op = MIDI_NOTE_OFF;
         EVT_NOTE_ON:    op = MIDI_NOTE_ON;
         EVT_POLY_AT:    op = MIDI_POLY_AT;
         default:        op = MIDI_PITCH_BEND;
      endcase
      return {op, channel};
   endfunction

endpackage

// File: rtl/midi_rs_cache.sv
// midi_rs_cache: running-status cache plus idle-timeout counter.
// Only compiled when MIDI_RUNNING_STATUS_EN is defined.
// The cache remembers the status byte of the last completed message; hit
// tells the encoder it may skip the status byte. After RS_TIMEOUT idle
// cycles the cache is dropped, and on the cycle the count is reached the
// timeout takes priority over a hit.
`ifdef MIDI_RUNNING_STATUS_EN
module midi_rs_cache #(
   parameter int RS_TIMEOUT = 9_600_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       msg_done,
   input  logic [7:0] status_in,
   input  logic       idle,
   output logic       hit
);

   localparam int CW = $clog2(RS_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(RS_TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(RS_TIMEOUT - 1);

   logic          valid_q, valid_d;
   logic [7:0]    cache_q, cache_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          timeout;

   // Next-state for the cache and the saturating idle counter
   always_comb begin
      valid_d = valid_q;
      cache_d = cache_q;
      cnt_d   = cnt_q;
      // This idle cycle is the one on which the count reaches RS_TIMEOUT
      timeout = idle && (cnt_q >= CNT_LAST);
      hit     = valid_q && (cache_q == status_in) && !timeout;
      if (msg_done) begin
         valid_d = 1'b1;
         cache_d = status_in;
         cnt_d   = '0;
      end else if (idle) begin
         if (cnt_q < CNT_MAX) cnt_d = cnt_q + CW'(1);
         if (timeout) valid_d = 1'b0;
      end
   end

   // Cache and counter registers; reset leaves the cache invalid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         cache_q <= 8'h00;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         cache_q <= cache_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
`endif

// File: rtl/midi_encoder.sv
// midi_encoder: turns synthesiser event strobes into a serial MIDI byte
// stream for the UART, with valid/ready on both sides.
// Optional feature: define MIDI_RUNNING_STATUS_EN to enable running status
// (status byte skipped when it repeats within RS_TIMEOUT idle cycles).
module midi_encoder
   import midi_pkg::*;
#(
   parameter int RS_TIMEOUT = 9_600_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       evt_valid,
   output logic       evt_ready,
   input  logic [1:0] evt_type,
   input  logic [3:0] channel,
   input  logic [6:0] note,
   input  logic [6:0] velocity,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy
);

   state_e     state_q, state_d;
   logic       evt_ready_q, evt_ready_d;
   logic       tx_valid_q, tx_valid_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic [6:0] note_q, note_d;
   logic [6:0] vel_q, vel_d;
   logic [7:0] evt_status;
   logic       accept;
   logic       hit;

   assign evt_status = midi_status(evt_type, channel);
   assign accept     = (state_q == ST_IDLE) && evt_valid && evt_ready_q;

`ifdef MIDI_RUNNING_STATUS_EN
   logic [7:0] status_q, status_d;
   logic [7:0] status_in;
   logic       msg_done;

   // Compare against the incoming event while idle, record the held one on completion
   assign status_in = (state_q == ST_IDLE) ? evt_status : status_q;
   assign msg_done  = (state_q == ST_DATA2) && tx_ready;

   // Capture the accepted message's status byte for recording at completion
   always_comb begin
      status_d = accept ? evt_status : status_q;
   end

   // Status holding register for the cache update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) status_q <= 8'h00;
      else        status_q <= status_d;
   end

   midi_rs_cache #(
      .RS_TIMEOUT (RS_TIMEOUT)
   ) u_rs_cache (
      .clk       (clk),
      .rst_n     (rst_n),
      .msg_done  (msg_done),
      .status_in (status_in),
      .idle      (state_q == ST_IDLE),
      .hit       (hit)
   );
`else
   assign hit = 1'b0;
`endif

   // Next state, registered outputs and event latch
   always_comb begin
      state_d     = state_q;
      evt_ready_d = evt_ready_q;
      tx_valid_d  = tx_valid_q;
      tx_data_d   = tx_data_q;
      note_d      = note_q;
      vel_d       = vel_q;
      case (state_q)
         ST_IDLE: begin
            evt_ready_d = 1'b1;
            if (accept) begin
               note_d      = note;
               vel_d       = velocity;
               evt_ready_d = 1'b0;
               tx_valid_d  = 1'b1;
               if (hit) begin
                  state_d   = ST_DATA1;
                  tx_data_d = {1'b0, note};
               end else begin
                  state_d   = ST_STATUS;
                  tx_data_d = evt_status;
               end
            end
         end
         ST_STATUS: begin
            if (tx_ready) begin
               state_d   = ST_DATA1;
               tx_data_d = {1'b0, note_q};
            end
         end
         ST_DATA1: begin
            if (tx_ready) begin
               state_d   = ST_DATA2;
               tx_data_d = {1'b0, vel_q};
            end
         end
         default: begin
            if (tx_ready) begin
               state_d     = ST_IDLE;
               tx_valid_d  = 1'b0;
               evt_ready_d = 1'b1;
            end
         end
      endcase
   end

   // FSM and output registers; reset abandons any message in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         evt_ready_q <= 1'b0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= 8'h00;
         note_q      <= 7'h00;
         vel_q       <= 7'h00;
      end else begin
         state_q     <= state_d;
         evt_ready_q <= evt_ready_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         note_q      <= note_d;
         vel_q       <= vel_d;
      end
   end

   assign evt_ready = evt_ready_q;
   assign tx_valid  = tx_valid_q;
   assign tx_data   = tx_data_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_midi_encoder.sv
// tb_midi_encoder: scoreboard bench for midi_encoder.
// The driver pushes expected bytes at event acceptance; a monitor pops and
// compares on every tx handshake. Running status is modelled as "last
// completed status, still fresh if accepted within RS_TIMEOUT idle cycles".
module tb_midi_encoder;

   localparam int T = 16;
`ifdef MIDI_RUNNING_STATUS_EN
   localparam bit RS_EN = 1'b1;
`else
   localparam bit RS_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       evt_valid = 1'b0;
   logic       evt_ready;
   logic [1:0] evt_type = 2'd0;
   logic [3:0] channel = 4'd0;
   logic [6:0] note = 7'd0;
   logic [6:0] velocity = 7'd0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   logic       busy;

   always #5 clk = ~clk;

   midi_encoder #(.RS_TIMEOUT(T)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_type  (evt_type),
      .channel   (channel),
      .note      (note),
      .velocity  (velocity),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .busy      (busy)
   );

   typedef struct {
      logic [7:0] b;
      bit         last;
      logic [7:0] st;
   } exp_t;

   exp_t       q[$];
   int         n_chk = 0;
   int         n_pass = 0;
   int         cyc = 0;
   int         done_cyc = 0;
   bit         m_valid = 1'b0;
   logic [7:0] m_status = 8'h00;
   int         rdy_mode = 0;
   bit         stall_prev = 1'b0;
   logic [7:0] data_prev = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [7:0] ref_status(input logic [1:0] t, input logic [3:0] ch);
      logic [7:0] base [4];
      base = '{8'h80, 8'h90, 8'hA0, 8'hE0};
      return base[t] + {4'h0, ch};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // tx_ready pattern: 0 = always high, 1 = toggling, 2 = random
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = ~tx_ready;
         default: tx_ready = ($urandom_range(0, 1) == 1);
      endcase
   end

   // Monitor: byte scoreboard, stall stability, ready/busy relation
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_valid", tx_valid, 1);
            check("stall_data", tx_data, data_prev);
         end
         if (busy) check("evt_ready_in_msg", evt_ready, 0);
         check("valid_eq_busy", tx_valid, busy);
         if (tx_valid && tx_ready) begin
            if (q.size() == 0) begin
               n_chk++;
               $display("FAIL spurious_byte: got %02h expected no byte (cycle %0d)", tx_data, cyc);
            end else begin
               e = q.pop_front();
               check("byte", tx_data, e.b);
               if (e.last) begin
                  m_valid  = 1'b1;
                  m_status = e.st;
                  done_cyc = cyc;
               end
            end
         end
         stall_prev = tx_valid && !tx_ready;
         data_prev  = tx_data;
      end
   end

   // Present one event, hold until accepted, push its expected bytes
   task automatic send(input logic [1:0] t, input logic [3:0] ch,
                       input logic [6:0] n, input logic [6:0] v);
      bit         acc;
      bit         hit;
      logic [7:0] st;
      acc = 1'b0;
      evt_type = t; channel = ch; note = n; velocity = v;
      evt_valid = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (evt_ready) begin
            acc = 1'b1;
            st  = ref_status(t, ch);
            hit = RS_EN && m_valid && (m_status == st) && ((cyc - done_cyc) < T);
            if (!hit) q.push_back('{b: st, last: 1'b0, st: st});
            q.push_back('{b: {1'b0, n}, last: 1'b0, st: st});
            q.push_back('{b: {1'b0, v}, last: 1'b1, st: st});
            $display("event type=%0d ch=%0d n=%02h v=%02h status=%02h hit=%0d", t, ch, n, v, st, hit);
            break;
         end
      end
      @(posedge clk);
      #1;
      evt_valid = 1'b0;
      evt_type  = 2'($urandom);
      channel   = 4'($urandom);
      note      = 7'($urandom);
      velocity  = 7'($urandom);
      if (acc) check("first_byte_latency", tx_valid, 1);
      else check("accept_timeout", acc, 1);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (!busy && q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("drain", ok, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_evt_ready", evt_ready, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_rst", evt_ready, 1);

      // Single note on, tx_ready high: three bytes on consecutive cycles
      rdy_mode = 0;
      @(posedge clk);
      #1;
      send(2'd1, 4'd3, 7'd60, 7'd100);
      repeat (2) @(posedge clk);
      #1;
      check("busy_last_byte", busy, 1);
      @(posedge clk);
      #1;
      check("busy_fall", busy, 0);
      wait_idle();

      // Back-to-back note ons on the same channel (running status case)
      send(2'd1, 4'd3, 7'd60, 7'd100);
      send(2'd1, 4'd3, 7'd64, 7'd0);
      wait_idle();

      // Pitch bend, long idle gap (timeout), repeat; then a short gap
      send(2'd3, 4'd0, 7'h00, 7'h40);
      wait_idle();
      repeat (T) @(posedge clk);
      #1;
      send(2'd3, 4'd0, 7'h00, 7'h40);
      wait_idle();
      repeat (5) @(posedge clk);
      #1;
      send(2'd3, 4'd0, 7'h00, 7'h40);
      wait_idle();

      // Back-pressure: tx_ready toggling every cycle
      rdy_mode = 1;
      send(2'd0, 4'd15, 7'd127, 7'd64);
      wait_idle();

      // Reset during DATA1, then resend the same event
      rdy_mode = 0;
      send(2'd0, 4'd15, 7'd127, 7'd64);
      @(posedge clk);
      #1;
      check("in_data1_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_tx_valid", tx_valid, 0);
      check("midrst_tx_data", tx_data, 8'h00);
      check("midrst_busy", busy, 0);
      check("midrst_evt_ready", evt_ready, 0);
      q.delete();
      m_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_midrst", evt_ready, 1);
      send(2'd0, 4'd15, 7'd127, 7'd64);
      wait_idle();

      // Type x channel sweep with all-ones data fields
      for (int t = 0; t < 4; t++) begin
         send(2'(t), 4'd0, 7'h7F, 7'h7F);
         wait_idle();
         send(2'(t), 4'd15, 7'h7F, 7'h7F);
         wait_idle();
      end

      // Randomised traffic: few statuses, random gaps and back-pressure
      rdy_mode = 2;
      for (int i = 0; i < 120; i++) begin
         repeat ($urandom_range(0, 22)) @(posedge clk);
         #1;
         send(2'($urandom_range(0, 1)), 4'($urandom_range(0, 1)),
              7'($urandom), 7'($urandom));
      end
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
